// File: rtl/wm8731_pkg.sv
// Shared constants and FSM state type for the WM8731 ADC deserializer.
package wm8731_pkg;

    localparam int WORD_W_DEFAULT = 16;
    localparam int BITS_PER_FRAME = 32;
    localparam int CNT_W          = $clog2(BITS_PER_FRAME);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        LEFT      = 2'd2,
        RIGHT     = 2'd3
    } state_e;

endpackage

// File: rtl/wm8731_edge_detect.sv
// Single-register edge detector for a level sampled in the clk domain.
module wm8731_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/wm8731_deserializer.sv
// Left-justified ADCDAT deserializer with valid/ready hand-off to the consumer.
//   state     | meaning
//   IDLE      | waiting for the en32k frame-start enable
//   WAIT_FALL | frame armed, waiting for the BCLK fall that opens the left word
//   LEFT      | shifting the left word, adc_lr_ck high
//   RIGHT     | shifting the right word, adc_lr_ck low after its first fall
module wm8731_deserializer
    import wm8731_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en32k,
    input  logic              bclk,
    input  logic              adc_dat,
    output logic              adc_lr_ck,
    output logic [WORD_W-1:0] audio_left,
    output logic [WORD_W-1:0] audio_right,
    output logic              audio_valid,
    input  logic              audio_ready,
    output logic              overrun,
    output logic              sync_err
);

    state_e              state_q, state_d;
    logic                lr_q, lr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   left_word_q, left_word_d;
    logic [WORD_W-1:0]   audio_left_q, audio_left_d;
    logic [WORD_W-1:0]   audio_right_q, audio_right_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                sync_err_q, sync_err_d;

    logic                bclk_rise, bclk_fall;
    logic [WORD_W-1:0]   shift_nxt;
    logic                word_done;
    logic                commit;

    wm8731_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bclk),
        .rise  (bclk_rise),
        .fall  (bclk_fall)
    );

    assign shift_nxt = {shift_q[WORD_W-2:0], adc_dat};
    assign word_done = bclk_rise && (cnt_q == CNT_W'(WORD_W - 1));

    always_comb begin
        state_d       = state_q;
        lr_d          = lr_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        left_word_d   = left_word_q;
        audio_left_d  = audio_left_q;
        audio_right_d = audio_right_q;
        valid_d       = valid_q;
        overrun_d     = 1'b0;
        sync_err_d    = 1'b0;
        commit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (en32k) state_d = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (bclk_fall) begin
                    state_d = LEFT;
                    lr_d    = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            LEFT, RIGHT: begin
                if (en32k) begin
                    // Frame start arrived early: drop the partial frame and resync.
                    state_d     = WAIT_FALL;
                    sync_err_d  = 1'b1;
                    lr_d        = 1'b0;
                    cnt_d       = '0;
                    shift_d     = '0;
                    left_word_d = '0;
                end else begin
                    if (state_q == RIGHT && bclk_fall) lr_d = 1'b0;
                    if (bclk_rise) begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_q + 1'b1;
                    end
                    if (word_done) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        if (state_q == LEFT) begin
                            left_word_d = shift_nxt;
                            state_d     = RIGHT;
                        end else begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            audio_left_d  = left_word_q;
            audio_right_d = shift_nxt;
            valid_d       = 1'b1;
            overrun_d     = valid_q && !audio_ready;
        end else if (valid_q && audio_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            lr_q          <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            left_word_q   <= '0;
            audio_left_q  <= '0;
            audio_right_q <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lr_q          <= lr_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            left_word_q   <= left_word_d;
            audio_left_q  <= audio_left_d;
            audio_right_q <= audio_right_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign adc_lr_ck   = lr_q;
    assign audio_left  = audio_left_q;
    assign audio_right = audio_right_q;
    assign audio_valid = valid_q;
    assign overrun     = overrun_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_wm8731_deserializer.sv
// Directed bench: a codec model drives ADCDAT on BCLK falls, checks use immediate assertions.
module tb_wm8731_deserializer;

    localparam int HALF = 4;

    logic        clk;
    logic        reset;
    logic        en32k;
    logic        bclk;
    logic        adc_dat;
    logic        adc_lr_ck;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        audio_valid;
    logic        audio_ready;
    logic        overrun;
    logic        sync_err;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int se_cnt = 0;

    wm8731_deserializer #(.WORD_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .en32k       (en32k),
        .bclk        (bclk),
        .adc_dat     (adc_dat),
        .adc_lr_ck   (adc_lr_ck),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .overrun     (overrun),
        .sync_err    (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    always @(negedge clk) begin
        if (overrun === 1'b1)  ov_cnt++;
        if (sync_err === 1'b1) se_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One BCLK period: data changes with the fall, DUT samples on the rise.
    task automatic period(input logic d, input bit last, output logic lr_s);
        bclk    = 1'b0;
        adc_dat = d;
        cyc(1);
        lr_s = adc_lr_ck;
        cyc(HALF - 1);
        bclk = 1'b1;
        if (!last) cyc(HALF);
    endtask

    // Returns right after driving the final rise, before the DUT has seen it.
    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int n,
                         output logic [31:0] pat);
        logic [31:0] bits;
        logic        s;
        bits = {l, r};
        pat  = '0;
        en32k = 1'b1;
        cyc(1);
        en32k = 1'b0;
        cyc(2);
        for (int k = 0; k < n; k++) begin
            period(bits[31-k], k == n - 1, s);
            pat[31-k] = s;
        end
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] bits;
        logic        s;

        reset       = 1'b0;
        en32k       = 1'b0;
        bclk        = 1'b1;
        adc_dat     = 1'b0;
        audio_ready = 1'b0;

        cyc(3);
        check("reset_valid", audio_valid, 0);
        check("reset_left",  audio_left,  0);
        check("reset_right", audio_right, 0);
        check("reset_lr",    adc_lr_ck,   0);
        check("reset_ovr",   overrun,     0);
        check("reset_serr",  sync_err,    0);
        reset = 1'b1;
        cyc(4);

        // Basic frame, consumer ready.
        audio_ready = 1'b1;
        frame(16'hA5C3, 16'h1234, 32, pat);
        check("lat_pre_valid", audio_valid, 0);
        cyc(1);
        check("f1_valid", audio_valid, 1);
        check("f1_left",  audio_left,  16'hA5C3);
        check("f1_right", audio_right, 16'h1234);
        check("f1_ovr",   overrun,     0);
        check("lr_pattern", pat, 32'hFFFF_0000);
        cyc(1);
        check("f1_valid_clear", audio_valid, 0);
        check("f1_left_hold",   audio_left,  16'hA5C3);
        check("f1_lr_after",    adc_lr_ck,   0);
        cyc(3);

        // Two frames with no consumer: second one overruns.
        audio_ready = 1'b0;
        frame(16'h0001, 16'h0002, 32, pat);
        cyc(1);
        check("f2_valid", audio_valid, 1);
        check("f2_left",  audio_left,  16'h0001);
        check("f2_right", audio_right, 16'h0002);
        check("f2_ovr",   overrun,     0);
        cyc(3);
        frame(16'hFFFF, 16'h8000, 32, pat);
        cyc(1);
        check("f3_ovr_pulse", overrun,     1);
        check("f3_valid",     audio_valid, 1);
        check("f3_left",      audio_left,  16'hFFFF);
        check("f3_right",     audio_right, 16'h8000);
        cyc(1);
        check("f3_ovr_end",   overrun, 0);
        check("f3_ovr_count", ov_cnt,  1);
        cyc(2);

        // Consumer accepts in the very cycle of the commit.
        frame(16'h1357, 16'h2468, 32, pat);
        audio_ready = 1'b1;
        cyc(1);
        audio_ready = 1'b0;
        check("f4_ovr",   overrun,     0);
        check("f4_valid", audio_valid, 1);
        check("f4_left",  audio_left,  16'h1357);
        check("f4_right", audio_right, 16'h2468);
        cyc(1);
        check("f4_valid_hold", audio_valid, 1);
        check("f4_ovr_count",  ov_cnt,      1);
        audio_ready = 1'b1;
        cyc(1);
        check("f4_valid_clear", audio_valid, 0);
        cyc(2);

        // Early en32k after 7 left bits, then a clean frame.
        frame(16'hFFFF, 16'hFFFF, 7, pat);
        cyc(2);
        en32k = 1'b1;
        cyc(1);
        en32k = 1'b0;
        check("abort_serr", sync_err,  1);
        check("abort_lr",   adc_lr_ck, 0);
        cyc(1);
        check("abort_serr_end", sync_err, 0);
        cyc(2);
        frame(16'h5555, 16'hAAAA, 32, pat);
        cyc(1);
        check("f5_valid",      audio_valid, 1);
        check("f5_left",       audio_left,  16'h5555);
        check("f5_right",      audio_right, 16'hAAAA);
        check("f5_lr_pattern", pat,         32'hFFFF_0000);
        check("f5_serr_count", se_cnt,      1);
        cyc(4);

        // Reset during the right word.
        audio_ready = 1'b0;
        frame(16'h1111, 16'h2222, 32, pat);
        cyc(1);
        check("f6_valid", audio_valid, 1);
        cyc(3);
        frame(16'h3333, 16'h4444, 20, pat);
        cyc(1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_valid", audio_valid, 0);
        check("rst_async_left",  audio_left,  0);
        check("rst_async_right", audio_right, 0);
        check("rst_async_lr",    adc_lr_ck,   0);
        check("rst_async_ovr",   overrun,     0);
        cyc(2);
        reset = 1'b1;
        cyc(HALF - 1);
        bits = 32'h3333_4444;
        for (int k = 20; k < 32; k++) period(bits[31-k], 1'b0, s);
        check("rst_no_valid", audio_valid, 0);
        check("rst_left_zero", audio_left, 0);
        frame(16'h6666, 16'h7777, 32, pat);
        cyc(1);
        check("f7_valid", audio_valid, 1);
        check("f7_left",  audio_left,  16'h6666);
        check("f7_right", audio_right, 16'h7777);
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wm8731_deserializer.md
WM8731_DESERIALIZER -- requirements
Module: wm8731_deserializer

Interface
- REQ-001 SHALL have parameter: WORD_W, 16, bits per channel word (left-justified format; 2*WORD_W BCLK periods per frame).
- REQ-002 SHALL have port: clk  input  1  240 MHz system clock; the only clock.
- REQ-003 SHALL have port: reset  input  1  reset, asynchronous assert, active-low.
- REQ-004 SHALL have port: en32k  input  1  one-cycle 32 kHz frame-start enable, synchronous to clk.
- REQ-005 SHALL have port: bclk  input  1  1.024 MHz bit clock as a level, generated in the clk domain.
- REQ-006 SHALL have port: adc_dat  input  1  WM8731 ADCDAT serial data.
- REQ-007 SHALL have port: adc_lr_ck  output  1  ADCLRC to codec; 1 = left word, 0 = right word.
- REQ-008 SHALL have port: audio_left  output  WORD_W  last complete left sample.
- REQ-009 SHALL have port: audio_right  output  WORD_W  last complete right sample.
- REQ-010 SHALL have port: audio_valid  output  1  sample pair held and not yet consumed.
- REQ-011 SHALL have port: audio_ready  input  1  consumer accepts the pair when high together with audio_valid.
- REQ-012 SHALL have port: overrun  output  1  one-cycle pulse when an unconsumed pair is overwritten.
- REQ-013 SHALL have port: sync_err  output  1  one-cycle pulse when en32k aborts a partial frame.

Function
- REQ-014 SHALL register bclk once and derive rise = bclk & ~bclk_q and fall = ~bclk & bclk_q; the logic acts on no other BCLK edges.
- REQ-015 SHALL implement FSM states IDLE, WAIT_FALL, LEFT, RIGHT.
- REQ-016 SHALL go IDLE -> WAIT_FALL on en32k.
- REQ-017 SHALL go WAIT_FALL -> LEFT on the next fall, set adc_lr_ck=1 and clear the 5-bit bit counter in that cycle.
- REQ-018 SHALL, in LEFT and RIGHT, shift adc_dat MSB-first into the shift register on each rise and increment the bit counter.
- REQ-019 SHALL, on the WORD_W-th rise in LEFT, capture the left word internally and go to RIGHT, with adc_lr_ck driven 0 on the following fall.
- REQ-020 SHALL, on the WORD_W-th rise in RIGHT, commit the left and right words to audio_left/audio_right, assert audio_valid the next cycle, and go to IDLE.
- REQ-021 SHALL, on en32k in LEFT or RIGHT, discard partial data, pulse sync_err for 1 cycle, drive adc_lr_ck=0, and go to WAIT_FALL.
- REQ-022 SHALL ignore en32k in WAIT_FALL; sync_err stays 0.
- REQ-023 SHALL clear audio_valid on a cycle with audio_valid && audio_ready when no commit occurs in that cycle.
- REQ-024 SHALL, on a commit while audio_valid=1 and audio_ready=0, overwrite the outputs, keep audio_valid=1, and pulse overrun.
- REQ-025 SHALL, on a commit in the same cycle as audio_valid && audio_ready, load the new pair, keep audio_valid=1, and leave overrun=0.
- REQ-026 SHALL keep audio_left/audio_right stable while audio_valid=1 except under REQ-024/025.
- REQ-027 SHALL have a latency of exactly 1 clk from the final rise to audio_valid.

Reset
- REQ-028 SHALL, on reset low, immediately force: state IDLE, adc_lr_ck 0, audio_left/right 0, audio_valid 0, overrun 0, sync_err 0, bclk_q 0, counter and shift register 0.
- REQ-029 SHALL discard any frame in progress on reset; after release the first capture starts at the next en32k.

Structure
- REQ-030 SHALL place the state enum, WORD_W default and BITS_PER_FRAME=32 in shared package wm8731_pkg.
- REQ-031 SHALL implement the BCLK edge detector as sub-module wm8731_edge_detect (ports clk, reset, d, rise, fall).
- REQ-032 SHALL use no additional clocks and no clock gating; bclk is used as data only.

Verification
- REQ-033 SHALL cover: en32k, codec model sends left 0xA5C3, right 0x1234, audio_ready=1 -> audio_valid 1 cycle, audio_left=0xA5C3, audio_right=0x1234.
- REQ-034 SHALL cover: adc_lr_ck check over one frame -> high for exactly 16 BCLK periods from first fall, low for 16.
- REQ-035 SHALL cover: two frames (0x0001/0x0002, then 0xFFFF/0x8000) with audio_ready=0 -> one overrun pulse; outputs 0xFFFF/0x8000; audio_valid=1.
- REQ-036 SHALL cover: en32k after 7 left bits -> sync_err pulse; next full frame 0x5555/0xAAAA captured correctly.
- REQ-037 SHALL cover: audio_ready asserted in the commit cycle -> no overrun; audio_valid stays 1 with the new pair.
- REQ-038 SHALL cover: reset low mid-RIGHT -> all outputs 0 asynchronously; no audio_valid until the next complete frame.
